// File: rtl/dblock_rule_writer_if.sv
// Command channel of the DBLOCK rule writer: one rule-group update per valid/ready transfer.
// Rule r occupies value/mask bits [r*kw_size +: kw_size]; en[r] gates the whole rule.
interface dblock_rule_writer_if #(
    parameter int kw_size = 5,
    parameter int D       = 64,
    parameter int GW      = $clog2(D / 8)
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [GW-1:0]          cmd_group;
    logic [8*kw_size-1:0]   cmd_value;
    logic [8*kw_size-1:0]   cmd_mask;
    logic [7:0]             cmd_en;

    modport master (
        output cmd_valid, cmd_group, cmd_value, cmd_mask, cmd_en,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_group, cmd_value, cmd_mask, cmd_en,
        output cmd_ready
    );
endinterface

// File: rtl/dblock_rule_writer.sv
// Expands one eight-rule ternary group update into the 32-cycle shift sequence on a
// DBLOCK array write port (key 31 shifted first, key 0 last). All outputs registered.
module dblock_rule_writer #(
    parameter int kw_size = 5,
    parameter int D       = 64,
    parameter int GW      = $clog2(D / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    dblock_rule_writer_if.slave  cmd,
    output logic [D/8-1:0]       we,
    output logic [7:0]           rules,
    output logic                 clr,
    output logic                 busy,
    output logic                 done
);
    localparam int KW = kw_size;
    localparam int NG = D / 8;
    localparam int VW = 8 * KW;
    localparam logic [KW-1:0] KEY_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_reg, state_next;
    logic [KW-1:0]   cnt_reg, cnt_next;
    logic [GW-1:0]   group_reg, group_next;
    logic [VW-1:0]   value_reg, value_next;
    logic [VW-1:0]   mask_reg, mask_next;
    logic [7:0]      en_reg, en_next;
    logic [NG-1:0]   we_reg, we_next;
    logic [7:0]      rules_reg, rules_next;
    logic            clr_reg, clr_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            ready_reg, ready_next;

    logic            accept;
    logic            in_idle;
    logic [KW-1:0]   shift_key;
    logic [VW-1:0]   src_value;
    logic [VW-1:0]   src_mask;
    logic [7:0]      src_en;
    logic [7:0]      rule_bit;
    logic [NG-1:0]   grp_onehot;

    assign in_idle = (state_reg == IDLE);
    assign accept  = cmd.cmd_valid & ready_reg;

    // The key for the next registered shift cycle: 31 right after accept, then counting down.
    // In IDLE the rule bits come straight from the command so key 31 is ready at T1.
    assign shift_key = in_idle ? KEY_MAX : (cnt_reg - KW'(1));
    assign src_value = in_idle ? cmd.cmd_value : value_reg;
    assign src_mask  = in_idle ? cmd.cmd_mask  : mask_reg;
    assign src_en    = in_idle ? cmd.cmd_en    : en_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rule
            assign rule_bit[gi] = src_en[gi] &
                (((shift_key ^ src_value[gi*KW +: KW]) & ~src_mask[gi*KW +: KW]) == '0);
        end
        for (gi = 0; gi < NG; gi++) begin : g_grp
            assign grp_onehot[gi] = (cmd.cmd_group == GW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        group_next = group_reg;
        value_next = value_reg;
        mask_next  = mask_reg;
        en_next    = en_reg;
        we_next    = '0;
        rules_next = '0;
        clr_next   = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        ready_next = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (accept) begin
                    group_next = cmd.cmd_group;
                    value_next = cmd.cmd_value;
                    mask_next  = cmd.cmd_mask;
                    en_next    = cmd.cmd_en;
                    cnt_next   = KEY_MAX;
                    state_next = SHIFT;
                    we_next    = grp_onehot;
                    rules_next = rule_bit;
                    clr_next   = 1'b1;
                    busy_next  = 1'b1;
                    ready_next = 1'b0;
                end
            end
            SHIFT: begin
                busy_next = 1'b1;
                // cnt_reg is the key currently on the port; key 0 is the last shift.
                if (cnt_reg == '0) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next   = cnt_reg - KW'(1);
                    we_next    = we_reg;
                    rules_next = rule_bit;
                    clr_next   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = KEY_MAX;
                ready_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = KEY_MAX;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= KEY_MAX;
            group_reg <= '0;
            value_reg <= '0;
            mask_reg  <= '0;
            en_reg    <= '0;
            we_reg    <= '0;
            rules_reg <= '0;
            clr_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            group_reg <= group_next;
            value_reg <= value_next;
            mask_reg  <= mask_next;
            en_reg    <= en_next;
            we_reg    <= we_next;
            rules_reg <= rules_next;
            clr_reg   <= clr_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ready_reg <= ready_next;
        end
    end

    assign cmd.cmd_ready = ready_reg;
    assign we            = we_reg;
    assign rules         = rules_reg;
    assign clr           = clr_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
endmodule

// File: tb/tb_dblock_rule_writer.sv
// Randomized bench for dblock_rule_writer: per-cycle port checks against the ternary rule
// definition, plus a behavioural DBLOCK array whose match bits are compared after each update.
module tb_dblock_rule_writer;
    localparam int KW = 5;
    localparam int D  = 64;
    localparam int NG = D / 8;
    localparam int GW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dblock_rule_writer_if #(.kw_size(KW), .D(D)) cif ();

    logic [NG-1:0] we;
    logic [7:0]    rules;
    logic          clr, busy, done;

    dblock_rule_writer #(.kw_size(KW), .D(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cif.slave),
        .we    (we),
        .rules (rules),
        .clr   (clr),
        .busy  (busy),
        .done  (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural DBLOCK array: each rule is a 32-bit shift register filled from address 0
    // upward, so the first bit shifted ends up at address 31.
    logic [31:0] arr [D];
    always @(posedge clk) begin
        for (int g = 0; g < NG; g++)
            if (we[g])
                for (int r = 0; r < 8; r++)
                    arr[g*8+r] <= {arr[g*8+r][30:0], rules[r]};
    end

    // A rule matches key k when k agrees with its value on every non-don't-care bit.
    function automatic logic [7:0] exp_bits(input logic [39:0] v, input logic [39:0] m,
                                             input logic [7:0] e, input int k);
        logic [7:0] b;
        logic [4:0] kk, vr, mr;
        kk = k[4:0];
        for (int r = 0; r < 8; r++) begin
            vr = v[r*5 +: 5];
            mr = m[r*5 +: 5];
            b[r] = e[r] && ((kk & ~mr) == (vr & ~mr));
        end
        return b;
    endfunction

    function automatic logic [19:0] port_vec();
        return {we, rules, clr, busy, cif.cmd_ready, done};
    endfunction

    localparam logic [19:0] IDLE_VEC = {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

    logic [GW-1:0] nxt_g;
    logic [39:0]   nxt_v, nxt_m;
    logic [7:0]    nxt_e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [GW-1:0] g, input logic [39:0] v, input logic [39:0] m,
                         input logic [7:0] e);
        cif.cmd_group = g;
        cif.cmd_value = v;
        cif.cmd_mask  = m;
        cif.cmd_en    = e;
    endtask

    function automatic logic [39:0] rand40();
        return 40'({$urandom(), $urandom()});
    endfunction

    // mode 0: drop valid and scramble inputs after accept; mode 1: keep valid high with a new
    // command in nxt_*; mode 2: assert rst during T10.
    task automatic send(input logic [GW-1:0] g, input logic [39:0] v, input logic [39:0] m,
                        input logic [7:0] e, input int mode, output int waited);
        logic [7:0] exp_we;
        exp_we = 8'(1) << g;
        drive(g, v, m, e);
        cif.cmd_valid = 1'b1;
        waited = 0;
        while (cif.cmd_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) begin
            check("accept_timeout", 64'(waited), 64'd0);
            cif.cmd_valid = 1'b0;
            return;
        end
        tick();
        if (mode == 1) begin
            nxt_g = GW'($urandom_range(0, NG-1));
            nxt_v = rand40();
            nxt_m = rand40();
            nxt_e = 8'($urandom());
            drive(nxt_g, nxt_v, nxt_m, nxt_e);
        end else begin
            cif.cmd_valid = 1'b0;
            drive(GW'($urandom()), rand40(), rand40(), 8'($urandom()));
        end
        for (int t = 1; t <= 32; t++) begin
            check($sformatf("shift_g%0d_T%0d", g, t), 64'(port_vec()),
                  64'({exp_we, exp_bits(v, m, e, 32 - t), 1'b1, 1'b1, 1'b0, 1'b0}));
            if (mode == 2 && t == 10) begin
                rst = 1'b1;
                tick();
                check("rst_T11", 64'(port_vec()), 64'(IDLE_VEC));
                rst = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    tick();
                    check($sformatf("rst_after_%0d", i), 64'(port_vec()), 64'(IDLE_VEC));
                end
                return;
            end
            tick();
        end
        check($sformatf("done_g%0d_T33", g), 64'(port_vec()),
              64'({8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1}));
        tick();
        check($sformatf("idle_g%0d_T34", g), 64'(port_vec()), 64'(IDLE_VEC));
    endtask

    task automatic check_group(input logic [GW-1:0] g, input logic [39:0] v,
                               input logic [39:0] m, input logic [7:0] e);
        logic [31:0] exp_match;
        logic [7:0]  b;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 32; k++) begin
                b = exp_bits(v, m, e, k);
                exp_match[k] = b[r];
            end
            check($sformatf("match_g%0d_r%0d", g, r), 64'(arr[g*8+r]), 64'(exp_match));
        end
    endtask

    initial begin
        logic [GW-1:0] g;
        logic [39:0]   v, m;
        logic [7:0]    e;
        int            w, mode;
        bit            chained;

        cif.cmd_valid = 1'b0;
        drive('0, '0, '0, '0);
        rst = 1'b1;
        repeat (3) tick();
        check("reset_state", 64'(port_vec()), 64'(IDLE_VEC));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_%0d", i), 64'(port_vec()), 64'(IDLE_VEC));
        end

        // single value-10 rule on group 2
        v = rand40(); v[4:0] = 5'h0A;
        m = rand40(); m[4:0] = 5'h00;
        send(3'd2, v, m, 8'h01, 0, w);
        check_group(3'd2, v, m, 8'h01);
        check("rule16_key10", 64'(arr[16]), 64'h0000_0400);

        // group 7: rule r value r, top bit don't-care
        for (int r = 0; r < 8; r++) begin
            v[r*5 +: 5] = 5'(r);
            m[r*5 +: 5] = 5'h10;
        end
        send(3'd7, v, m, 8'hFF, 0, w);
        check_group(3'd7, v, m, 8'hFF);
        check("rule59_keys", 64'(arr[59]), 64'h0008_0008);

        // all rules disabled, then a match-everything rule
        g = GW'($urandom_range(0, NG-1));
        v = rand40(); m = rand40();
        send(g, v, m, 8'h00, 0, w);
        check_group(g, v, m, 8'h00);
        m[4:0] = 5'h1F;
        send(g, v, m, 8'h01, 0, w);
        check_group(g, v, m, 8'h01);
        check("match_all", 64'(arr[g*8]), 64'hFFFF_FFFF);

        // back-to-back with valid held high
        g = 3'd4; v = rand40(); m = rand40(); e = 8'($urandom());
        send(g, v, m, e, 1, w);
        check_group(g, v, m, e);
        send(nxt_g, nxt_v, nxt_m, nxt_e, 0, w);
        check("b2b_wait", 64'(w), 64'd0);
        check_group(nxt_g, nxt_v, nxt_m, nxt_e);

        // reset mid-sequence, then rewrite the group
        g = 3'd1; v = rand40(); m = rand40(); e = 8'($urandom());
        send(g, v, m, e, 2, w);
        e = 8'($urandom());
        send(g, v, m, e, 0, w);
        check_group(g, v, m, e);

        // reset wins over a same-cycle command
        drive(3'd3, rand40(), rand40(), 8'hFF);
        cif.cmd_valid = 1'b1;
        rst = 1'b1;
        tick();
        cif.cmd_valid = 1'b0;
        rst = 1'b0;
        check("rst_vs_valid", 64'(port_vec()), 64'(IDLE_VEC));
        tick();
        check("rst_vs_valid_next", 64'(port_vec()), 64'(IDLE_VEC));

        // random commands, optionally chained back-to-back
        g = GW'($urandom()); v = rand40(); m = rand40(); e = 8'($urandom());
        chained = 1'b0;
        for (int n = 0; n < 10; n++) begin
            mode = (n == 9) ? 0 : int'($urandom_range(0, 1));
            send(g, v, m, e, mode, w);
            if (chained) check($sformatf("rand_b2b_wait_%0d", n), 64'(w), 64'd0);
            check_group(g, v, m, e);
            if (mode == 1) begin
                g = nxt_g; v = nxt_v; m = nxt_m; e = nxt_e;
                chained = 1'b1;
            end else begin
                g = GW'($urandom()); v = rand40(); m = rand40(); e = 8'($urandom());
                if ($urandom_range(0, 3) == 0) m[4:0] = 5'h1F;
                chained = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
